// File: rtl/down_count_monitor_if.sv
// Bus between the upstream down counter and the down-count monitor.
// The master drives count samples; the slave reports tracking status.
interface down_count_monitor_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
);
    logic             cnt_valid;
    logic [W-1:0]     cnt_in;
    logic             locked;
    logic             tc_pulse;
    logic             wrap_pulse;
    logic             err_pulse;
    logic [CNT_W-1:0] wrap_count;
    logic [CNT_W-1:0] err_count;
    logic [W-1:0]     last_value;

    modport master (
        output cnt_valid, cnt_in,
        input  locked, tc_pulse, wrap_pulse, err_pulse, wrap_count, err_count, last_value
    );

    modport slave (
        input  cnt_valid, cnt_in,
        output locked, tc_pulse, wrap_pulse, err_pulse, wrap_count, err_count, last_value
    );
endinterface

// File: rtl/down_count_monitor.sv
// Checks that a sampled down-counter steps by exactly -1 (mod 2^W), reporting terminal
// count, wrap and step errors as pulses with saturating tallies and a lock indicator.
module down_count_monitor #(
    parameter int unsigned W      = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear_i,
    down_count_monitor_if.slave  mon_io
);
    localparam int unsigned GoodW = 8;
    localparam logic [GoodW-1:0] LockN = GoodW'(LOCK_N);

    typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

    state_e           state_q, state_d;
    logic [GoodW-1:0] good_q, good_d;
    logic [W-1:0]     last_q, last_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             tc_q, tc_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [W-1:0]     exp_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            good_q     <= '0;
            last_q     <= '0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
            tc_q       <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            last_q     <= last_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_cnt_q  <= err_cnt_d;
            tc_q       <= tc_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        last_d     = last_q;
        wrap_cnt_d = wrap_cnt_q;
        err_cnt_d  = err_cnt_q;
        tc_d       = 1'b0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;
        exp_val    = last_q - W'(1);

        if (clear_i) begin
            // Clear outranks a simultaneous sample, which is dropped.
            state_d    = StIdle;
            good_d     = '0;
            last_d     = '0;
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (mon_io.cnt_valid) begin
            last_d = mon_io.cnt_in;
            unique case (state_q)
                StIdle: begin
                    state_d = StAcq;
                    good_d  = '0;
                end
                StAcq, StLocked: begin
                    if (mon_io.cnt_in == exp_val) begin
                        tc_d   = (mon_io.cnt_in == '0);
                        // A good step out of 0 can only land on all-ones.
                        wrap_d = (last_q == '0);
                        if (wrap_d && (wrap_cnt_q != '1)) begin
                            wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
                        end
                        if (state_q == StAcq) begin
                            good_d = good_q + GoodW'(1);
                            if (good_d == LockN) begin
                                state_d = StLocked;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = StAcq;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign mon_io.locked     = (state_q == StLocked);
    assign mon_io.tc_pulse   = tc_q;
    assign mon_io.wrap_pulse = wrap_q;
    assign mon_io.err_pulse  = err_q;
    assign mon_io.wrap_count = wrap_cnt_q;
    assign mon_io.err_count  = err_cnt_q;
    assign mon_io.last_value = last_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor: two instances (8-bit and 2-bit tallies) share
// stimulus; a behavioural model queues expected outputs that are checked after each edge.
module tb_down_count_monitor;
    localparam int unsigned W      = 4;
    localparam int unsigned LOCK_N = 4;

    logic clk = 1'b0;
    logic reset;
    logic clear;

    always #5 clk = ~clk;

    down_count_monitor_if #(.W(W), .CNT_W(8)) if_a ();
    down_count_monitor_if #(.W(W), .CNT_W(2)) if_b ();

    down_count_monitor #(.W(W), .CNT_W(8), .LOCK_N(LOCK_N)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .mon_io  (if_a.slave)
    );

    down_count_monitor #(.W(W), .CNT_W(2), .LOCK_N(LOCK_N)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .mon_io  (if_b.slave)
    );

    typedef struct {
        bit locked;
        bit tc;
        bit wrap;
        bit err;
        int wraps;
        int errs;
        int last;
    } exp_t;

    exp_t sb[$];
    int   m_state, m_good, m_last, m_wraps, m_errs;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_good  = 0;
        m_last  = 0;
        m_wraps = 0;
        m_errs  = 0;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, " a.locked"}, 32'(if_a.locked), 32'(e.locked));
        check({tag, " a.tc"}, 32'(if_a.tc_pulse), 32'(e.tc));
        check({tag, " a.wrap"}, 32'(if_a.wrap_pulse), 32'(e.wrap));
        check({tag, " a.err"}, 32'(if_a.err_pulse), 32'(e.err));
        check({tag, " a.wrap_count"}, 32'(if_a.wrap_count), 32'(sat(e.wraps, 255)));
        check({tag, " a.err_count"}, 32'(if_a.err_count), 32'(sat(e.errs, 255)));
        check({tag, " a.last"}, 32'(if_a.last_value), 32'(e.last));
        check({tag, " b.locked"}, 32'(if_b.locked), 32'(e.locked));
        check({tag, " b.err"}, 32'(if_b.err_pulse), 32'(e.err));
        check({tag, " b.wrap_count"}, 32'(if_b.wrap_count), 32'(sat(e.wraps, 3)));
        check({tag, " b.err_count"}, 32'(if_b.err_count), 32'(sat(e.errs, 3)));
    endtask

    // Drive one cycle of stimulus, predict its result, then check after the edge.
    task automatic step(input string tag, input bit clr, input bit valid, input int val);
        exp_t e;
        bit   tc   = 1'b0;
        bit   wrap = 1'b0;
        bit   err  = 1'b0;
        int   expv;
        clear          = clr;
        if_a.cnt_valid = valid;
        if_b.cnt_valid = valid;
        if_a.cnt_in    = val[3:0];
        if_b.cnt_in    = val[3:0];
        if (clr) begin
            model_reset();
        end else if (valid) begin
            expv = (m_last + 15) % 16;
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else if (val == expv) begin
                tc   = (val == 0);
                wrap = (m_last == 0);
                if (wrap) m_wraps++;
                if (m_state == 1) begin
                    m_good++;
                    if (m_good == LOCK_N) m_state = 2;
                end
            end else begin
                err = 1'b1;
                m_errs++;
                m_good  = 0;
                m_state = 1;
            end
            m_last = val;
        end
        e = '{locked: (m_state == 2), tc: tc, wrap: wrap, err: err,
              wraps: m_wraps, errs: m_errs, last: m_last};
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag, sb.pop_front());
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '{locked: 1'b0, tc: 1'b0, wrap: 1'b0, err: 1'b0, wraps: 0, errs: 0, last: 0};
        compare(tag, z);
    endtask

    initial begin
        reset          = 1'b1;
        clear          = 1'b0;
        if_a.cnt_valid = 1'b0;
        if_b.cnt_valid = 1'b0;
        if_a.cnt_in    = '0;
        if_b.cnt_in    = '0;
        model_reset();
        #12;
        reset = 1'b0;
        check_zero("reset");

        // Lock acquisition: baseline F then four good steps.
        for (int v = 15; v >= 11; v--) step("lock", 1'b0, 1'b1, v);
        step("idle_gap", 1'b0, 1'b0, 0);

        // Run through terminal count and wrap.
        for (int v = 10; v >= 0; v--) step("tc", 1'b0, 1'b1, v);
        step("wrap", 1'b0, 1'b1, 15);

        // Skip from 5 to 3 while locked, then relock through 0 -> F.
        for (int v = 14; v >= 5; v--) step("pre_err", 1'b0, 1'b1, v);
        step("skip", 1'b0, 1'b1, 3);
        step("relock", 1'b0, 1'b1, 2);
        step("relock", 1'b0, 1'b1, 1);
        step("relock_tc", 1'b0, 1'b1, 0);
        step("relock_wrap", 1'b0, 1'b1, 15);

        // Stall on 7, then repeat to saturate the 2-bit error tally.
        step("jump7", 1'b0, 1'b1, 7);
        step("stall", 1'b0, 1'b1, 7);
        for (int i = 0; i < 3; i++) step("sat", 1'b0, 1'b1, 7);

        // Relock, then asynchronous reset between edges.
        for (int v = 6; v >= 3; v--) step("lock2", 1'b0, 1'b1, v);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("async_reset");
        #2;
        reset = 1'b0;

        step("base0", 1'b0, 1'b1, 0);
        step("after_base", 1'b0, 1'b1, 15);
        step("clear_valid", 1'b1, 1'b1, 14);
        step("post_clear", 1'b0, 1'b1, 13);
        step("post_clear2", 1'b0, 1'b1, 12);
        step("quiet", 1'b0, 1'b0, 0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0d expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
